exception_unit: RTL

- Commit-stage exception and interrupt arbiter. It drives the exception/eret inputs of the CP0 register file and consumes CP0's Status, Cause and EPC values.
- Prioritises exception flags from the retiring instruction against pending interrupts.
- Produces a one-cycle CP0 update, the pipeline flush window and the fetch redirect (handler vector or EPC).
- Also registers the hardware interrupt lines fed into CP0.

---
 rtl/exception_unit.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/exception_unit.sv
// ---------------------------------------------------------------------------
// exception_unit
//
// Commit-stage exception and interrupt arbiter. Looks at the exception flags
// of the retiring instruction together with the pending-interrupt state held
// in CP0. It then produces:
//   - a one-cycle update for the CP0 register file (cause code, PC, delay-slot
//     flag, eret pulse)
//   - a pipeline flush window of FLUSH_CYCLES cycles
//   - a one-cycle fetch redirect, either to the handler vector or to EPC
// It also registers the hardware interrupt lines that feed CP0.
//
// Optional feature (macro EXC_BADVADDR_EN):
//   When defined, the ports o_badvaddr and o_badvaddr_we are added. They
//   report the faulting address for address-error exceptions (cause 4/5).
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   i_valid, i_pc          retiring instruction valid and its PC
//   i_in_delay_slot        retiring instruction sits in a branch delay slot
//   i_adel_if .. i_ades    exception flags of the retiring instruction
//   i_eret                 retiring instruction is eret
//   i_bad_vaddr            faulting data address (load/store address errors)
//   i_status/i_cause/i_epc CP0 Status, Cause and EPC
//   i_cp0_we/waddr/wdata   same-cycle mtc0 write (used for the EPC bypass)
//   i_hw_int, i_timer_int  external interrupt lines and CP0 timer interrupt
//   o_except_cause         cause code to CP0, 5'b11111 when there is no event
//   o_current_pc           PC of the excepting instruction, to CP0
//   o_is_in_delay_slot     delay-slot flag, to CP0
//   o_is_eret              eret pulse, to CP0
//   o_int                  registered interrupt lines, to CP0
//   o_flush                pipeline flush
//   o_redirect_valid/pc    fetch redirect pulse and its target
// ---------------------------------------------------------------------------
module exception_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic        i_in_delay_slot,
  input  logic        i_adel_if,
  input  logic        i_ri,
  input  logic        i_ov,
  input  logic        i_syscall,
  input  logic        i_break,
  input  logic        i_adel_ld,
  input  logic        i_ades,
  input  logic        i_eret,
  input  logic [31:0] i_bad_vaddr,
  input  logic [31:0] i_status,
  input  logic [31:0] i_cause,
  input  logic [31:0] i_epc,
  input  logic        i_cp0_we,
  input  logic [4:0]  i_cp0_waddr,
  input  logic [31:0] i_cp0_wdata,
  input  logic [5:0]  i_hw_int,
  input  logic        i_timer_int,
  output logic [4:0]  o_except_cause,
  output logic [31:0] o_current_pc,
  output logic        o_is_in_delay_slot,
  output logic        o_is_eret,
  output logic [5:0]  o_int,
  output logic        o_flush,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc
`ifdef EXC_BADVADDR_EN
  ,
  output logic [31:0] o_badvaddr,
  output logic        o_badvaddr_we
`endif
);

  localparam logic [4:0] CAUSE_NONE    = 5'b11111;
  localparam logic [4:0] CAUSE_INT     = 5'd0;
  localparam logic [4:0] CAUSE_ADEL    = 5'd4;
  localparam logic [4:0] CAUSE_ADES    = 5'd5;
  localparam logic [4:0] CAUSE_SYSCALL = 5'd8;
  localparam logic [4:0] CAUSE_BREAK   = 5'd9;
  localparam logic [4:0] CAUSE_RI      = 5'd10;
  localparam logic [4:0] CAUSE_OV      = 5'd12;
  localparam logic [4:0] EPC_ADDR      = 5'd14;

  // The counter is loaded with the number of flush cycles still to come
  // after the first one, so it reaches zero on the last flush cycle.
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_FLUSH
  } state_t;

  state_t      state;
  logic [3:0]  flush_cnt;

  logic        int_pending;
  logic        exc_hit;
  logic [4:0]  exc_code;
  logic        bad_from_pc;
  logic [31:0] eret_target;

  // Decode the retiring instruction. Interrupts win over every synchronous
  // exception. EXL (Status[1]) masks only interrupts, so a faulting
  // instruction is still reported while EXL is set. An eret that also
  // carries a fault is handled as that fault: the eret check only happens
  // when exc_hit is clear.
  always_comb begin
    int_pending = (|(i_cause[15:8] & i_status[15:8])) && i_status[0] && !i_status[1];
    exc_hit     = 1'b1;
    exc_code    = CAUSE_NONE;
    bad_from_pc = 1'b0;
    if (int_pending) begin
      exc_code = CAUSE_INT;
    end else if (i_adel_if) begin
      exc_code    = CAUSE_ADEL;
      bad_from_pc = 1'b1;
    end else if (i_ri) begin
      exc_code = CAUSE_RI;
    end else if (i_ov) begin
      exc_code = CAUSE_OV;
    end else if (i_syscall) begin
      exc_code = CAUSE_SYSCALL;
    end else if (i_break) begin
      exc_code = CAUSE_BREAK;
    end else if (i_adel_ld) begin
      exc_code = CAUSE_ADEL;
    end else if (i_ades) begin
      exc_code = CAUSE_ADES;
    end else begin
      exc_hit = 1'b0;
    end
  end

  // An mtc0 to EPC in the same cycle as the eret has not reached CP0 yet.
  // Forward its data so the return goes to the freshly written address.
  assign eret_target = (i_cp0_we && (i_cp0_waddr == EPC_ADDR)) ? i_cp0_wdata : i_epc;

  // The interrupt lines are sampled every cycle, whatever the FSM state.
  // The timer interrupt shares line 5 with the external line 5.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_int <= 6'b0;
    end else begin
      o_int <= {i_hw_int[5] | i_timer_int, i_hw_int[4:0]};
    end
  end

  // Main FSM. All outputs are registered here.
  // Pulse outputs default back to their idle values every cycle, so any
  // event shows up for exactly one cycle. o_current_pc and the delay-slot
  // flag keep their last value for CP0. While the flush window is open,
  // every instruction input is ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state              <= ST_IDLE;
      flush_cnt          <= 4'd0;
      o_except_cause     <= CAUSE_NONE;
      o_current_pc       <= 32'd0;
      o_is_in_delay_slot <= 1'b0;
      o_is_eret          <= 1'b0;
      o_flush            <= 1'b0;
      o_redirect_valid   <= 1'b0;
      o_redirect_pc      <= 32'd0;
`ifdef EXC_BADVADDR_EN
      o_badvaddr         <= 32'd0;
      o_badvaddr_we      <= 1'b0;
`endif
    end else begin
      o_except_cause   <= CAUSE_NONE;
      o_is_eret        <= 1'b0;
      o_redirect_valid <= 1'b0;
`ifdef EXC_BADVADDR_EN
      o_badvaddr_we    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (i_valid && exc_hit) begin
            o_except_cause     <= exc_code;
            o_current_pc       <= i_pc;
            o_is_in_delay_slot <= i_in_delay_slot;
            o_redirect_valid   <= 1'b1;
            o_redirect_pc      <= EXC_VECTOR;
            o_flush            <= 1'b1;
            flush_cnt          <= FLUSH_LAST;
            state              <= ST_FLUSH;
`ifdef EXC_BADVADDR_EN
            if (exc_code == CAUSE_ADEL || exc_code == CAUSE_ADES) begin
              o_badvaddr_we <= 1'b1;
              o_badvaddr    <= bad_from_pc ? i_pc : i_bad_vaddr;
            end
`endif
          end else if (i_valid && i_eret) begin
            o_is_eret        <= 1'b1;
            o_redirect_valid <= 1'b1;
            o_redirect_pc    <= eret_target;
            o_flush          <= 1'b1;
            flush_cnt        <= FLUSH_LAST;
            state            <= ST_FLUSH;
          end else begin
            o_flush <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 4'd0) begin
            o_flush <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_flush <= 1'b0;
        end
      endcase
    end
  end

  // Collect the input bits this block never looks at, so lint sees them used.
  logic unused_bits;
`ifdef EXC_BADVADDR_EN
  assign unused_bits = ^{i_status[31:16], i_status[7:2], i_cause[31:16], i_cause[7:0]};
`else
  assign unused_bits = ^{i_status[31:16], i_status[7:2], i_cause[31:16], i_cause[7:0],
                         i_bad_vaddr, bad_from_pc};
`endif

endmodule
